multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Multi-cycle wide adder/subtractor. It reuses one 16-bit carry-skip adder slice and walks it over WORDS slices of the operands, least significant slice first, holding the carry in a register between cycles.
- Accepts operands through a valid/ready handshake and returns the sum, carry-out and signed overflow through a second valid/ready handshake.
- Sits between the arithmetic datapath and the control logic that needs additions wider than 16 bits.

Parameters:
- W, 16, slice width in bits; fixed by the adder slice, so only 16 is supported.
- WORDS, 4, number of slices per operation; legal range 2..8; total width N = W*WORDS.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  high only in IDLE.
- op_a  in  N  operand A.
- op_b  in  N  operand B.
- sub  in  1  1 computes A-B; 0 computes A+B+cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  result, registered.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, slice index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on in_valid&&in_ready.
  - Capture op_a into the A register.
  - Capture op_b into the B register; when sub=1, store ~op_b.
  - Load the carry register with sub ? 1 : cin.
  - Set index=0.
- RUN, one slice per cycle:
  - The slice adder takes A[idx*W +: W], B[idx*W +: W] and the carry register.
  - Its s output is written into sum[idx*W +: W]; its cout is written into the carry register.
  - idx increments each cycle.
  - On the cycle idx==WORDS-1, the slice's cout also loads cout.
  - On that same cycle, ovf = (A_msb == B_msb) && (s_msb != A_msb), where B_msb is the inverted one when sub=1.
  - RUN -> DONE on that same cycle.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_ready. DONE -> IDLE on out_ready.
- Latency: accept edge -> out_valid high after exactly WORDS+1 rising edges. The accept cycle does not compute.
- Throughput: one operation per WORDS+2 cycles when out_ready is held at 1.
- sum bits not yet written in the current operation keep their previous value. Only the DONE value is architecturally valid.
- in_valid asserted during RUN or DONE is ignored and not queued, because in_ready=0.
- out_ready asserted while not in DONE has no effect.
- in_valid and out_ready high together in DONE: the result is consumed and the FSM goes to IDLE. The new request is accepted on the next cycle; there is no same-cycle restart.
- Holding out_ready=0 stalls in DONE indefinitely with outputs stable.
- The index counter is clog2(WORDS) bits wide. It is compared against WORDS-1, never wrapped, and cleared on accept.
- rst_n asserted mid-RUN or in DONE aborts immediately. All outputs return to their reset values and the partial result is discarded.
- Carry chain: the slice cout of word k is the carry-in of word k+1 on the next cycle. The slice's internal skip logic handles propagation within a slice.

Decomposition:
- Shared package holds:
  - SLICE_W = 16.
  - State encoding typedef {IDLE=2'd0, RUN=2'd1, DONE=2'd2}.
  - MAX_WORDS = 8.
- One sub-module: a single instance of carry_skip_adder_16bit as the slice datapath, fed by slice muxes.
- The FSM, counter and operand/result registers live in multiword_add_sequencer.

Test Plan:
- Reset, then add with WORDS=4: A=64'h0000_0000_0000_FFFF, B=64'h1, cin=0 -> sum=64'h0000_0000_0001_0000, cout=0, ovf=0. out_valid rises 5 edges after accept.
- Full carry ripple across all slices: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum=0, cout=1, ovf=0.
- Subtract: A=64'h5, B=64'h7, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0. A=64'h8000_0000_0000_0000, B=1, sub=1 -> sum=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, sum and cout stay constant; in_ready stays 0; in_valid pulses during this time are ignored. Releasing out_ready gives in_ready=1 on the next cycle.
- Reset mid-operation: pull rst_n low on the 2nd RUN cycle -> out_valid=0, sum=0, in_ready=1 asynchronously. A following operation 64'h1234 + 64'h1 gives 64'h1235.
- Back-to-back: two requests with in_valid held high and out_ready=1 -> results 3+4=7, then 10+20=30. Accepts are spaced exactly WORDS+2=6 cycles apart.

Source files
------------

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared constants and FSM encoding for the multi-word add/subtract sequencer.
package multiword_add_sequencer_pkg;
  localparam int SLICE_W   = 16;
  localparam int MAX_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand request and result handshakes of the multi-word add/subtract sequencer.
interface multiword_add_sequencer_if #(parameter int WORDS = 4);
  import multiword_add_sequencer_pkg::*;
  localparam int N = SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport slave (
    input  in_valid, op_a, op_b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  modport master (
    output in_valid, op_a, op_b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/multiword_add_sequencer_slice.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each bypassed when all its bits propagate.
module carry_skip_adder_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_s,
  output logic        o_cout
);
  for (genvar gi = 0; gi < 4; gi++) begin : blk
    logic       w_ci;
    logic       w_co;
    logic       w_p;
    logic       w_rc;
    logic [3:0] w_s;

    if (gi == 0) begin : g_first
      assign w_ci = i_cin;
    end else begin : g_chain
      assign w_ci = blk[gi-1].w_co;
    end

    always_comb begin : ripple
      logic c_run;
      w_s   = '0;
      c_run = w_ci;
      for (int k = 0; k < 4; k++) begin
        w_s[k] = i_a[4*gi+k] ^ i_b[4*gi+k] ^ c_run;
        c_run  = (i_a[4*gi+k] & i_b[4*gi+k]) | (c_run & (i_a[4*gi+k] ^ i_b[4*gi+k]));
      end
      w_rc = c_run;
    end

    // A fully-propagating block passes its carry-in straight through.
    assign w_p            = &(i_a[4*gi +: 4] ^ i_b[4*gi +: 4]);
    assign w_co           = w_p ? w_ci : w_rc;
    assign o_s[4*gi +: 4] = w_s;
  end

  assign o_cout = blk[3].w_co;
endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built by walking one 16-bit slice adder over WORDS slices, LSB slice first.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int W     = SLICE_W,
  parameter int WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multiword_add_sequencer_if.slave    bus
);
  localparam int N     = W * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  state_t             r_state;
  state_t             w_state_next;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_b;
  logic [N-1:0]       r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;

  logic [W-1:0]       w_a_slice;
  logic [W-1:0]       w_b_slice;
  logic [W-1:0]       w_s;
  logic               w_c;
  logic               w_accept;
  logic               w_last;

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_last    = (r_idx == IDX_W'(WORDS - 1));
  assign w_a_slice = r_a[r_idx*W +: W];
  assign w_b_slice = r_b[r_idx*W +: W];

  carry_skip_adder_16bit u_slice (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // B is stored pre-inverted for subtract, so the MSB test below covers both operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_idx*W +: W] <= w_s;
      r_carry             <= w_c;
      if (w_last) begin
        r_cout <= w_c;
        r_ovf  <= (r_a[N-1] == r_b[N-1]) && (w_s[W-1] != r_a[N-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer with WORDS=4 (64-bit operands).
module tb_multiword_add_sequencer;
  localparam int WORDS = 4;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_pushed = 0;
  int   cyc = 0;
  exp_t sb[$];

  multiword_add_sequencer_if #(.WORDS(WORDS)) bus ();

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: 65-bit arithmetic and signed-overflow rules for add/sub.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic sub, input logic cin);
    exp_t        e;
    logic [64:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 65'd1;
    else     r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    e.sum  = r[63:0];
    e.cout = r[64];
    if (sub) e.ovf = (a[63] != b[63]) && (r[63] != a[63]);
    else     e.ovf = (a[63] == b[63]) && (r[63] != a[63]);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sum", bus.sum, e.sum);
        check("cout", {63'd0, bus.cout}, {63'd0, e.cout});
        check("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
        n_done++;
        $display("txn %0d: sum=%h cout=%b ovf=%b", n_done, bus.sum, bus.cout, bus.ovf);
      end
    end
  end

  task automatic push_exp(input logic [63:0] s, input logic c, input logic o);
    sb.push_back('{sum: s, cout: c, ovf: o});
    n_pushed++;
  endtask

  // Called at posedge+1; returns at accept posedge+1 with the accept cycle in acc.
  task automatic drive_req(input logic [63:0] a, input logic [63:0] b, input logic sub,
                           input logic cin, input bit hold, output int acc);
    int t;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = sub;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        input logic cin, input exp_t e);
    int acc;
    int lat;
    push_exp(e.sum, e.cout, e.ovf);
    drive_req(a, b, sub, cin, 1'b0, acc);
    wait_out_valid(lat);
    check("latency", lat, WORDS);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          acc1;
    int          acc2;
    int          lat;
    logic [63:0] held_sum;
    logic        held_cout;
    exp_t        e;

    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_sum", bus.sum, 64'd0);
    check("rst_cout_ovf", {62'd0, bus.cout, bus.ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, '{sum: 64'h0000_0000_0001_0000, cout: 1'b0, ovf: 1'b0});
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, '{sum: 64'h0, cout: 1'b1, ovf: 1'b0});
    run_op(64'h5, 64'h7, 1'b1, 1'b0, '{sum: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b0, ovf: 1'b0});
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, '{sum: 64'h7FFF_FFFF_FFFF_FFFF, cout: 1'b1, ovf: 1'b1});
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, '{sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1});

    for (int i = 0; i < 6; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;
      logic        rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, rc, model(ra, rb, rs, rc));
    end

    // Back-pressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    e = model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
    push_exp(e.sum, e.cout, e.ovf);
    drive_req(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 1'b0, acc1);
    wait_out_valid(lat);
    check("bp_latency", lat, WORDS);
    held_sum  = bus.sum;
    held_cout = bus.cout;
    check("bp_sum_value", held_sum, 64'h1234_6789_BCDF_1234);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'(i % 2);
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("bp_sum", bus.sum, held_sum);
      check("bp_cout", {63'd0, bus.cout}, {63'd0, held_cout});
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("bp_no_queued_op", {63'd0, bus.busy}, 64'd0);

    // Reset on the second RUN cycle aborts the operation.
    drive_req(64'h0000_0000_0000_ABCD, 64'h1, 1'b0, 1'b0, 1'b0, acc1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("abort_sum", bus.sum, 64'd0);
    check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(64'h1234, 64'h1, 1'b0, 1'b0, '{sum: 64'h1235, cout: 1'b0, ovf: 1'b0});

    // Back-to-back with in_valid held high.
    bus.out_ready = 1'b1;
    push_exp(64'd7, 1'b0, 1'b0);
    drive_req(64'd3, 64'd4, 1'b0, 1'b0, 1'b1, acc1);
    push_exp(64'd30, 1'b0, 1'b0);
    drive_req(64'd10, 64'd20, 1'b0, 1'b0, 1'b0, acc2);
    check("b2b_spacing", acc2 - acc1, WORDS + 2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
    check("done_count", n_done, n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
